// File: rtl/wb2axi_ddr_pkg.sv
// Shared types and AXI constants for the Wishbone-to-AXI4 DDR bridge.
package wb2axi_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/wb2axi_ddr_bridge.sv
// Wishbone B3 classic slave to single-beat AXI4 master, one transaction in flight.
// Optional wait-state watchdog with drain: define WB2AXI_DDR_TIMEOUT_EN.
module wb2axi_ddr_bridge
  import wb2axi_ddr_pkg::*;
#(
  parameter logic [3:0] AXI_ID         = 4'd0,
  parameter int         ADDR_WIDTH     = 28,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [3:0]            m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [3:0]            m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [3:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [3:0]            m_axi_rid,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_t                state, state_nx, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            sel_q;
  logic                  aw_done, w_done, cyc_lost;
  logic                  req, aw_hs, w_hs, ar_hs;
  logic                  unused_inputs;

  function automatic logic resp_ok(input logic [1:0] resp);
    resp_ok = 1'b0;
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:  resp_ok = 1'b1;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: resp_ok = 1'b0;
    endcase
  endfunction

  // A new request is not taken while the previous response pulse is still visible.
  assign req   = (state == ST_IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;

  assign wb_rty_o      = 1'b0;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = sel_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;

  assign unused_inputs = ^{wb_adr_i, wb_cti_i, wb_bte_i, m_axi_bid, m_axi_rid, m_axi_rlast};

  // Request capture: only updated in IDLE, so AXI payload stays stable while valid.
  always_ff @(posedge clk) begin
    if (req) begin
      addr_q  <= {wb_adr_i[ADDR_WIDTH-1:2], 2'b00};
      wdata_q <= wb_dat_i;
      sel_q   <= wb_sel_i;
    end
  end

`ifdef WB2AXI_DDR_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        is_wr, rsp_seen, busy, tmo_hit, drain_done, b_hs, r_hs;

  assign b_hs    = m_axi_bvalid && m_axi_bready;
  assign r_hs    = m_axi_rvalid && m_axi_rready;
  assign busy    = (state == ST_WR) || (state == ST_WR_RESP) ||
                   (state == ST_RD_ADDR) || (state == ST_RD_DATA);
  assign tmo_hit = busy && (state_nx == state) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign drain_done = (!m_axi_awvalid || aw_hs) && (!m_axi_wvalid || w_hs) &&
                      (!m_axi_arvalid || ar_hs) && (rsp_seen || b_hs || r_hs);
  assign state_d = tmo_hit ? ST_DRAIN : state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt  <= '0;
      is_wr    <= 1'b0;
      rsp_seen <= 1'b0;
    end else begin
      if (state_d != state) tmo_cnt <= '0;
      else if (busy)        tmo_cnt <= tmo_cnt + 16'd1;
      if (req) is_wr <= wb_we_i;
      if (tmo_hit) rsp_seen <= 1'b0;
      else if ((state == ST_DRAIN) && (b_hs || r_hs)) rsp_seen <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign state_d = state_nx;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (req) state_nx = wb_we_i ? ST_WR : ST_RD_ADDR;
      ST_WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = ST_WR_RESP;
      ST_WR_RESP: if (m_axi_bvalid) state_nx = ST_IDLE;
      ST_RD_ADDR: if (m_axi_arready) state_nx = ST_RD_DATA;
      ST_RD_DATA: if (m_axi_rvalid) state_nx = ST_IDLE;
`ifdef WB2AXI_DDR_TIMEOUT_EN
      ST_DRAIN:   if (drain_done) state_nx = ST_IDLE;
`endif
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_rready  <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      wb_dat_o      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cyc_lost      <= 1'b0;
    end else begin
      state    <= state_d;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (aw_hs) begin
        m_axi_awvalid <= 1'b0;
        aw_done       <= 1'b1;
      end
      if (w_hs) begin
        m_axi_wvalid <= 1'b0;
        w_done       <= 1'b1;
      end
      if (ar_hs) m_axi_arvalid <= 1'b0;
      // An abandoned Wishbone cycle still completes on AXI but gets no response.
      if ((state != ST_IDLE) && !wb_cyc_i) cyc_lost <= 1'b1;
      case (state)
        ST_IDLE: if (req) begin
          cyc_lost      <= 1'b0;
          aw_done       <= 1'b0;
          w_done        <= 1'b0;
          m_axi_awvalid <= wb_we_i;
          m_axi_wvalid  <= wb_we_i;
          m_axi_arvalid <= !wb_we_i;
        end
        ST_WR: if (state_d == ST_WR_RESP) m_axi_bready <= 1'b1;
        ST_WR_RESP: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          if (wb_cyc_i && !cyc_lost) begin
            wb_ack_o <= resp_ok(m_axi_bresp);
            wb_err_o <= !resp_ok(m_axi_bresp);
          end
        end
        ST_RD_ADDR: if (m_axi_arready) m_axi_rready <= 1'b1;
        ST_RD_DATA: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          wb_dat_o     <= m_axi_rdata;
          if (wb_cyc_i && !cyc_lost) begin
            wb_ack_o <= resp_ok(m_axi_rresp);
            wb_err_o <= !resp_ok(m_axi_rresp);
          end
        end
`ifdef WB2AXI_DDR_TIMEOUT_EN
        ST_DRAIN: if (b_hs || r_hs) begin
          m_axi_bready <= 1'b0;
          m_axi_rready <= 1'b0;
        end
`endif
        default: ;
      endcase
`ifdef WB2AXI_DDR_TIMEOUT_EN
      if (tmo_hit) begin
        wb_err_o     <= 1'b1;
        m_axi_bready <= is_wr;
        m_axi_rready <= !is_wr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb2axi_ddr_bridge.sv
// Scoreboard bench for wb2axi_ddr_bridge with a cycle-based AXI slave model.
module tb_wb2axi_ddr_bridge;

`ifdef WB2AXI_DDR_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [3:0]  m_axi_awid, m_axi_awcache, m_axi_awqos, m_axi_arid, m_axi_arcache, m_axi_arqos;
  logic [27:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_bid, m_axi_rid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  wb2axi_ddr_bridge #(.AXI_ID(4'd0), .ADDR_WIDTH(28), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_cnt = 0;

  typedef struct {
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;
  exp_t sb_q[$];

  // Slave model configuration and expected AXI payload
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic [27:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  bit          chk_bready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every ack/err pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && (wb_ack_o || wb_err_o)) begin
      exp_t e;
      resp_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_kind", {62'd0, wb_ack_o, wb_err_o}, {62'd0, !e.err, e.err});
        if (e.chk_dat) check("rd_data", {32'd0, wb_dat_o}, {32'd0, e.dat});
      end
    end
  end

  // AXI slave: readies after a programmable delay, responses after another.
  initial begin
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit aw_got, w_got, ar_got, b_take, r_take;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_take = 0; r_take = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rid = 0;
    m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_take = 0; r_take = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        continue;
      end
      if (m_axi_awready) begin
        m_axi_awready = 0; aw_got = 1;
      end else if (m_axi_awvalid) begin
        check("aw_fields", {8'd0, m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                            m_axi_awcache, m_axi_awprot, m_axi_awqos},
                           {8'd0, exp_addr, 4'h0, 8'h00, 3'b010, 2'b01, 4'b0011, 3'b000, 4'h0});
        if (aw_wait >= aw_dly) begin m_axi_awready = 1; aw_wait = 0; end
        else aw_wait++;
      end
      if (m_axi_wready) begin
        m_axi_wready = 0; w_got = 1;
      end else if (m_axi_wvalid) begin
        check("w_fields", {27'd0, m_axi_wdata, m_axi_wstrb, m_axi_wlast},
                          {27'd0, exp_wdata, exp_wstrb, 1'b1});
        if (w_wait >= w_dly) begin m_axi_wready = 1; w_wait = 0; end
        else w_wait++;
      end
      if (chk_bready && m_axi_bready)
        check("bready_early", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd0);
      if (m_axi_bvalid) begin
        if (b_take) begin m_axi_bvalid = 0; b_take = 0; end
        else b_take = m_axi_bready;
      end else if (aw_got && w_got) begin
        if (b_wait >= b_dly) begin
          m_axi_bvalid = 1; m_axi_bresp = bresp_cfg;
          aw_got = 0; w_got = 0; b_wait = 0; b_take = m_axi_bready;
        end else b_wait++;
      end
      if (m_axi_arready) begin
        m_axi_arready = 0; ar_got = 1;
      end else if (m_axi_arvalid) begin
        check("ar_fields", {8'd0, m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                            m_axi_arcache, m_axi_arprot, m_axi_arqos},
                           {8'd0, exp_addr, 4'h0, 8'h00, 3'b010, 2'b01, 4'b0011, 3'b000, 4'h0});
        if (ar_wait >= ar_dly) begin m_axi_arready = 1; ar_wait = 0; end
        else ar_wait++;
      end
      if (m_axi_rvalid) begin
        if (r_take) begin m_axi_rvalid = 0; r_take = 0; end
        else r_take = m_axi_rready;
      end else if (ar_got) begin
        if (r_wait >= r_dly) begin
          m_axi_rvalid = 1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg; m_axi_rlast = 1;
          ar_got = 0; r_wait = 0; r_take = m_axi_rready;
        end else r_wait++;
      end
    end
  end

  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic exp_err, input logic chk_dat,
                          input logic [31:0] exp_dat, output int lat);
    exp_t e;
    e.err = exp_err; e.chk_dat = chk_dat; e.dat = exp_dat;
    sb_q.push_back(e);
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(wb_ack_o || wb_err_o) && lat < 200);
    if (lat >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL wb_timeout: no ack/err after %0d cycles, expected a response", lat);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic [27:0] xaddr, input logic xerr, output int lat);
    exp_addr = xaddr; exp_wdata = dat; exp_wstrb = sel;
    wb_cycle(1'b1, adr, dat, sel, xerr, 1'b0, 32'd0, lat);
  endtask

  task automatic do_read(input logic [31:0] adr, input logic [27:0] xaddr, input logic [31:0] rd,
                         input logic [1:0] rr, input logic xerr, output int lat);
    exp_addr = xaddr; rdata_cfg = rd; rresp_cfg = rr;
    wb_cycle(1'b0, adr, 32'd0, 4'hF, xerr, !xerr, rd, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat, r0, n;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                       m_axi_rready, wb_ack_o, wb_err_o}, 64'd0);
    check("rst_dat", {32'd0, wb_dat_o}, 64'd0);
    check("rty_tied", {63'd0, wb_rty_o}, 64'd0);
    #2 rst = 1'b0;

    do_write(32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 28'h000_0104, 1'b0, lat);
    check("wr_latency", lat, 3);

    r_dly = 5;
    do_read(32'h0000_0104, 28'h000_0104, 32'hCAFE_F00D, 2'b00, 1'b0, lat);
    check("rd_wait_latency", lat, 8);

    r_dly = 0;
    do_read(32'h0ABC_DEF7, 28'hABC_DEF4, 32'h1234_5678, 2'b01, 1'b0, lat);
    check("rd_latency", lat, 3);

    aw_dly = 4; w_dly = 0;
    do_write(32'h1000_0200, 32'h1122_3344, 4'b1100, 28'h000_0200, 1'b0, lat);
    check("wr_aw_late_latency", lat, 7);

    aw_dly = 0; w_dly = 4; bresp_cfg = 2'b11;
    do_write(32'h0000_0300, 32'hA5A5_5A5A, 4'b1111, 28'h000_0300, 1'b1, lat);
    check("wr_w_late_latency", lat, 7);
    w_dly = 0; bresp_cfg = 2'b00;

    do_read(32'h0000_0400, 28'h000_0400, 32'h0BAD_0BAD, 2'b10, 1'b1, lat);

    do_read(32'h0000_0500, 28'h000_0500, 32'h7777_8888, 2'b00, 1'b0, lat);

    // Reset asserted mid-read, away from any clock edge
    r_dly = 20; exp_addr = 28'h000_0600;
    @(negedge clk);
    wb_adr_i = 32'h0000_0600; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    while (!m_axi_rready && n < 50) begin @(negedge clk); n++; end
    check("rd_data_reached", {63'd0, m_axi_rready}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                             m_axi_rready, wb_ack_o, wb_err_o}, 64'd0);
    check("async_rst_dat", {32'd0, wb_dat_o}, 64'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    r_dly = 0;
    do_read(32'h0000_0700, 28'h000_0700, 32'h0F0F_0F0F, 2'b00, 1'b0, lat);
    check("post_rst_latency", lat, 3);

    // Wishbone master abandons the cycle; AXI side must still finish silently
    r_dly = 3; exp_addr = 28'h000_0800; rdata_cfg = 32'h5555_AAAA;
    @(negedge clk);
    wb_adr_i = 32'h0000_0800; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    r0 = resp_cnt;
    repeat (12) @(negedge clk);
    check("cyc_drop_no_resp", resp_cnt - r0, 0);
    check("cyc_drop_idle", {62'd0, m_axi_arvalid, m_axi_rready}, 64'd0);
    r_dly = 0;
    do_write(32'h0000_0900, 32'hFEED_FACE, 4'b0101, 28'h000_0900, 1'b0, lat);

`ifdef WB2AXI_DDR_TIMEOUT_EN
    chk_bready = 1'b0; aw_dly = 40;
    do_write(32'h0000_0A00, 32'h0102_0304, 4'b1111, 28'h000_0A00, 1'b1, lat);
    check("tmo_err_window", {63'd0, (lat >= 16 && lat <= 18)}, 64'd1);
    r0 = resp_cnt;
    repeat (50) @(negedge clk);
    check("drain_no_resp", resp_cnt - r0, 0);
    check("drain_idle", {61'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 64'd0);
    aw_dly = 0; chk_bready = 1'b1;
    do_write(32'h0000_0B00, 32'h0A0B_0C0D, 4'b0011, 28'h000_0B00, 1'b0, lat);
    check("post_drain_latency", lat, 3);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb2axi_ddr_bridge.md
Name: wb2axi_ddr_bridge

Overview:
Wishbone B3 slave to AXI4 master bridge that feeds the board-level DDR AXI slave port. It converts each single Wishbone classic cycle into one single-beat AXI4 transaction: 32-bit data, 28-bit byte address, one outstanding transaction. It sits between the system bus DDR slave port and the board DDR port, in the sys_clk/sys_rst domain.

Parameters:
AXI_ID, 0, 4-bit ID driven on m_axi_awid and m_axi_arid
ADDR_WIDTH, 28, AXI byte-address width; taken from wb_adr_i[ADDR_WIDTH-1:0]
TIMEOUT_CYCLES, 1024, wait-state watchdog limit (only used with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wb_adr_i/wb_dat_i  in  32/32  Wishbone byte address / write data
wb_sel_i  in  4  byte selects
wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  write enable, cycle, strobe
wb_cti_i/wb_bte_i  in  3/2  accepted and ignored; every access is single-beat
wb_dat_o  out  32  read data
wb_ack_o, wb_err_o, wb_rty_o  out  1 each  acknowledge, error, retry (wb_rty_o tied 0)
m_axi_aw{id,addr,len,size,burst,cache,prot,qos}  out  4/ADDR_WIDTH/8/3/2/4/3/4  write address
m_axi_awvalid out 1; m_axi_awready in 1
m_axi_wdata out 32; m_axi_wstrb out 4; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1
m_axi_bid in 4; m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1
m_axi_ar{id,addr,len,size,burst,cache,prot,qos}  out  same widths as aw  read address
m_axi_arvalid out 1; m_axi_arready in 1
m_axi_rid in 4; m_axi_rdata in 32; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1

Behaviour:
- Static fields: len=0, size=3'b010, burst=2'b01 (INCR), cache=4'b0011, prot=0, qos=0, wlast=1, id=AXI_ID.
- Request sampling: the address, data and sel are registered in IDLE when wb_cyc_i & wb_stb_i. The registered address has bits [1:0] forced to 0. wstrb = registered wb_sel_i.
- States: IDLE, WR (aw and w outstanding), WR_RESP, RD_ADDR, RD_DATA, and DRAIN (optional feature only).
- IDLE -> WR when we=1; awvalid and wvalid both rise in the next cycle.
- IDLE -> RD_ADDR when we=0; arvalid rises.
- WR:
  - awvalid drops on awvalid&awready; wvalid drops on wvalid&wready. Each is tracked by its own done flag, so either order, or both in the same cycle, is legal.
  - When both are done -> WR_RESP, with bready=1.
- WR_RESP: on bvalid, -> IDLE.
  - wb_ack_o=1 for one cycle if bresp[1]==0.
  - Otherwise wb_err_o=1 for one cycle.
- RD_ADDR: on arready -> RD_DATA, with rready=1.
- RD_DATA: on rvalid, wb_dat_o <= rdata, -> IDLE.
  - ack or err is chosen by rresp[1], as in WR_RESP.
  - rlast is ignored; it is always 1 because len=0.
- Ack/err timing: registered one-cycle pulse, asserted in the cycle the FSM re-enters IDLE. A request can be sampled in IDLE no earlier than the cycle after that pulse.
- Latency: best case ack 3 cycles after stb is sampled (write and read).
- AXI valids: never deasserted before their handshake; address and data are stable while valid.
- wb_cyc_i dropping mid-transaction: the AXI transaction still completes, and the ack is suppressed.
- Reset: async; FSM to IDLE; all valids, bready, rready, ack, err = 0; wb_dat_o = 0.
- No ID checking; bid and rid are ignored.

Optional Feature:
- Macro WB2AXI_DDR_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on each state entry and increments in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT_CYCLES, wb_err_o pulses once and the FSM -> DRAIN.
  - DRAIN finishes the pending AXI handshakes (valids held, bready/rready=1) silently, then -> IDLE.
  - No Wishbone response is given for the drained transaction.
- Undefined: no counter, no DRAIN state; the bridge waits indefinitely.

Decomposition:
- Package wb2axi_ddr_pkg holds:
  - the state enum;
  - constants AXI_SIZE_4B, AXI_BURST_INCR, AXI_CACHE_DEFAULT, and AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
- No sub-module; the timeout counter is inline.

Test Plan:
- Write 0x0000_0104 <= 0xDEADBEEF, sel=4'b0011; slave awready=wready=1, bresp=0 -> awaddr=0x0000104, wstrb=0011, awlen=0, awsize=2; one ack 3 cycles after stb.
- Read 0x0000_0104; slave returns rdata=0xCAFEF00D, rresp=0 after 5 wait cycles -> wb_dat_o=0xCAFEF00D, single ack, no err.
- Write with wready 4 cycles before awready, then the reverse order -> bready asserted only after both handshakes; valids held stable while stalled.
- Read with rresp=2'b10 (SLVERR) -> wb_err_o one cycle, wb_ack_o stays 0.
- Assert rst while in RD_DATA -> all valids/readys/ack/err 0 immediately (asynchronously); the next read completes normally.
- With WB2AXI_DDR_TIMEOUT_EN and TIMEOUT_CYCLES=16, awready held 0 -> err at cycle 16; a later awready/wready/bvalid is drained with no ack, then back to IDLE.
